// File: rtl/pipeline_skid_reg_if.sv
// Valid/ready handshake bundle for one elastic pipeline stage.
// The stage itself connects through the slave modport; the producer/consumer
// side (or a testbench) uses the master modport.
interface pipeline_skid_reg_if #(
  parameter int unsigned WIDTH = 32
);

  // Upstream side: producer offers in_data, stage answers with in_ready
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  // Downstream side: stage offers out_data, consumer answers with out_ready
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // Number of words currently held by the stage (0..2)
  logic [1:0]       occupancy;

  // Environment view: drives payload and downstream ready, observes the stage
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  occupancy
  );

  // Stage view
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output occupancy
  );

endinterface : pipeline_skid_reg_if

// File: rtl/pipeline_skid_reg.sv
// Elastic pipeline stage register with a 2-entry skid buffer.
// in_ready and out_valid are decoded from the registered state only, so a
// downstream stall never creates a combinational path back to the producer.
// The head register always holds CLEAR_VALUE while the stage is empty.
module pipeline_skid_reg #(
  parameter int unsigned     WIDTH       = 32,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = {WIDTH{1'b0}}
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  pipeline_skid_reg_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;

  logic             in_ready_c;
  logic             out_valid_c;
  logic             in_fire_c;
  logic             out_fire_c;
  logic [1:0]       occupancy_c;

  // Handshake decode from registered state; reset forces both sides idle
  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    occupancy_c = 2'd0;
    if (!reset) begin
      in_ready_c  = (state_q != ST_FULL);
      out_valid_c = (state_q != ST_EMPTY);
    end
    case (state_q)
      ST_EMPTY: occupancy_c = 2'd0;
      ST_ONE:   occupancy_c = 2'd1;
      ST_FULL:  occupancy_c = 2'd2;
      default:  occupancy_c = 2'd0;
    endcase
    in_fire_c  = bus.in_valid & in_ready_c;
    out_fire_c = out_valid_c & bus.out_ready;
  end

  // Next-state and storage update; flush overrides the handshake result
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    case (state_q)
      ST_EMPTY: begin
        if (in_fire_c) begin
          state_d = ST_ONE;
          main_d  = bus.in_data;
        end
      end

      ST_ONE: begin
        if (in_fire_c && out_fire_c) begin
          main_d = bus.in_data;
        end else if (in_fire_c) begin
          state_d = ST_FULL;
          skid_d  = bus.in_data;
        end else if (out_fire_c) begin
          state_d = ST_EMPTY;
          main_d  = CLEAR_VALUE;
        end
      end

      ST_FULL: begin
        // in_ready is low here, so only the drain side can move
        if (out_fire_c) begin
          state_d = ST_ONE;
          main_d  = skid_q;
          skid_d  = CLEAR_VALUE;
        end
      end

      default: begin
        state_d = ST_EMPTY;
        main_d  = CLEAR_VALUE;
        skid_d  = CLEAR_VALUE;
      end
    endcase

    // A word delivered this cycle stays delivered; anything held or accepted is dropped
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = CLEAR_VALUE;
      skid_d  = CLEAR_VALUE;
    end
  end

  // State and payload registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= CLEAR_VALUE;
      skid_q  <= CLEAR_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = main_q;
  assign bus.occupancy = occupancy_c;

endmodule : pipeline_skid_reg
